// File: rtl/pipelined_control_unit_pkg.sv
// Shared opcode/ALUOp constants and per-stage control bundle types for the
// pipelined control unit.
package pipelined_control_unit_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_SB   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_bundle_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic branch;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    function automatic mem_ctrl_t to_mem(ctrl_bundle_t c);
        return '{memread: c.memread, memwrite: c.memwrite, branch: c.branch,
                 memtoreg: c.memtoreg, regwrite: c.regwrite};
    endfunction

    function automatic wb_ctrl_t to_wb(mem_ctrl_t c);
        return '{memtoreg: c.memtoreg, regwrite: c.regwrite};
    endfunction

endpackage

// File: rtl/pipelined_control_unit_ctrl_decode.sv
// Combinational ID-stage decoder: opcode to control bundle plus operand-use flags.
module ctrl_decode
    import pipelined_control_unit_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output ctrl_bundle_t ctrl_o,
    output logic         rs1_used_o,
    output logic         rs2_used_o
);

    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b0;
        case (opcode_i)
            OPC_R: begin
                ctrl_o.aluop    = ALUOP_R;
                ctrl_o.regwrite = 1'b1;
                rs2_used_o      = 1'b1;
            end
            OPC_LD: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.aluop    = ALUOP_ADD;
            end
            OPC_ADDI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = ALUOP_ADD;
            end
            OPC_S: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.aluop    = ALUOP_ADD;
                rs2_used_o      = 1'b1;
            end
            OPC_SB: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluop  = ALUOP_BR;
                rs2_used_o    = 1'b1;
            end
            default: rs1_used_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control unit for the 5-stage pipeline: decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall and branch flush. Optional perf counters: PIPELINED_CONTROL_UNIT_PERF_EN.
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int ALUOP_W      = 2,
    parameter int BRANCH_STAGE = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  pipe_hold,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  ex_alusrc,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_branch,
    output logic                  ex_memtoreg,
    output logic                  ex_regwrite,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_branch,
    output logic                  mem_memtoreg,
    output logic                  mem_regwrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_rd
`ifdef PIPELINED_CONTROL_UNIT_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    generate
        if (BRANCH_STAGE != 1 && BRANCH_STAGE != 2) begin : g_bad_branch_stage
            $error("BRANCH_STAGE must be 1 (EX) or 2 (MEM)");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("CNT_W must be at least 1");
        end
    endgenerate

    ctrl_bundle_t          id_ctrl;
    logic                  rs1_used, rs2_used;
    ctrl_bundle_t          idex_q, idex_d;
    mem_ctrl_t             exmem_q, exmem_d;
    wb_ctrl_t              memwb_q, memwb_d;
    logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d, exmem_rd_q, exmem_rd_d, memwb_rd_q, memwb_rd_d;
    logic                  lu, lu_eff;

    ctrl_decode u_decode (
        .opcode_i   (id_opcode),
        .ctrl_o     (id_ctrl),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    assign lu = idex_q.memread && (idex_rd_q != '0) &&
                ((rs1_used && idex_rd_q == id_rs1) || (rs2_used && idex_rd_q == id_rs2));
    // A flush kills the dependent instruction anyway, so it outranks the stall.
    assign lu_eff = lu && !branch_taken;

    assign pc_write   = reset_n && !pipe_hold && !lu_eff;
    assign ifid_write = pc_write;
    assign ifid_flush = !reset_n || (!pipe_hold && branch_taken);

    always_comb begin
        idex_d     = idex_q;
        idex_rd_d  = idex_rd_q;
        exmem_d    = exmem_q;
        exmem_rd_d = exmem_rd_q;
        memwb_d    = memwb_q;
        memwb_rd_d = memwb_rd_q;
        if (!pipe_hold) begin
            memwb_d    = to_wb(exmem_q);
            memwb_rd_d = exmem_rd_q;
            exmem_d    = to_mem(idex_q);
            exmem_rd_d = idex_rd_q;
            idex_d     = id_ctrl;
            idex_rd_d  = id_rd;
            if (branch_taken || lu) begin
                idex_d    = CTRL_BUBBLE;
                idex_rd_d = '0;
            end
            if (branch_taken && BRANCH_STAGE == 2) begin
                exmem_d    = '0;
                exmem_rd_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_q     <= CTRL_BUBBLE;
            idex_rd_q  <= '0;
            exmem_q    <= '0;
            exmem_rd_q <= '0;
            memwb_q    <= '0;
            memwb_rd_q <= '0;
        end else begin
            idex_q     <= idex_d;
            idex_rd_q  <= idex_rd_d;
            exmem_q    <= exmem_d;
            exmem_rd_q <= exmem_rd_d;
            memwb_q    <= memwb_d;
            memwb_rd_q <= memwb_rd_d;
        end
    end

    assign ex_alusrc    = idex_q.alusrc;
    assign ex_aluop     = ALUOP_W'(idex_q.aluop);
    assign ex_memread   = idex_q.memread;
    assign ex_memwrite  = idex_q.memwrite;
    assign ex_branch    = idex_q.branch;
    assign ex_memtoreg  = idex_q.memtoreg;
    assign ex_regwrite  = idex_q.regwrite;
    assign ex_rd        = idex_rd_q;
    assign mem_memread  = exmem_q.memread;
    assign mem_memwrite = exmem_q.memwrite;
    assign mem_branch   = exmem_q.branch;
    assign mem_memtoreg = exmem_q.memtoreg;
    assign mem_regwrite = exmem_q.regwrite;
    assign mem_rd       = exmem_rd_q;
    assign wb_memtoreg  = memwb_q.memtoreg;
    assign wb_regwrite  = memwb_q.regwrite;
    assign wb_rd        = memwb_rd_q;

`ifdef PIPELINED_CONTROL_UNIT_PERF_EN
    logic [CNT_W-1:0] stall_count_q, flush_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else if (!pipe_hold) begin
            if (lu_eff)       stall_count_q <= stall_count_q + 1'b1;
            if (branch_taken) flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
